// File: rtl/serial_paral_rx_cond.sv
// Serial-to-parallel receiver with comma-based byte alignment and lock detection.
// Optional build macro RX_BYTE_COUNT_EN adds a saturating rx_byte_count output.
module serial_paral_rx_cond #(
  parameter logic [7:0] COMMA        = 8'hBC,
  parameter int         BC_THRESHOLD = 4
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
`ifdef RX_BYTE_COUNT_EN
  ,
  output logic [7:0] rx_byte_count
`endif
);

  // state    | meaning
  // SEARCH   | hunting for COMMA at every bit offset
  // LOCKING  | byte-aligned, counting consecutive COMMAs
  // ACTIVE   | locked, reporting non-COMMA bytes until reset
  typedef enum logic [1:0] {SEARCH, LOCKING, ACTIVE} state_t;

  localparam int BCW = (BC_THRESHOLD < 2) ? 1 : $clog2(BC_THRESHOLD + 1);
  localparam logic [BCW-1:0] BC_MAX = BCW'(BC_THRESHOLD);

  state_t         state;
  // Only the seven youngest bits of the 8-bit window feed the next candidate.
  logic [6:0]     sr;
  logic [2:0]     cnt;
  logic [BCW-1:0] bc_count;
  logic [7:0]     cand;
  logic           boundary;

  assign cand     = {sr, serial_in};
  assign boundary = (cnt == 3'd7);

  always_ff @(posedge clk_8f) begin
    if (reset) begin
      state     <= SEARCH;
      sr        <= '0;
      cnt       <= '0;
      bc_count  <= '0;
      data_out  <= 8'h00;
      valid_out <= 1'b0;
      active    <= 1'b0;
`ifdef RX_BYTE_COUNT_EN
      rx_byte_count <= 8'h00;
`endif
    end else begin
      sr        <= cand[6:0];
      valid_out <= 1'b0;
      case (state)
        SEARCH: begin
          if (cand == COMMA) begin
            cnt      <= 3'd0;
            bc_count <= BCW'(1);
            if (BC_THRESHOLD <= 1) begin
              state  <= ACTIVE;
              active <= 1'b1;
            end else begin
              state  <= LOCKING;
            end
          end
        end
        LOCKING: begin
          cnt <= cnt + 3'd1;
          if (boundary) begin
            if (cand == COMMA) begin
              if (bc_count >= BC_MAX - 1'b1) begin
                bc_count <= BC_MAX;
                state    <= ACTIVE;
                active   <= 1'b1;
              end else begin
                bc_count <= bc_count + 1'b1;
              end
            end else begin
              // The failing byte is consumed here, not re-scanned for COMMA.
              state    <= SEARCH;
              bc_count <= '0;
              cnt      <= 3'd0;
            end
          end
        end
        ACTIVE: begin
          cnt <= cnt + 3'd1;
          if (boundary && cand != COMMA) begin
            data_out  <= cand;
            valid_out <= 1'b1;
`ifdef RX_BYTE_COUNT_EN
            if (rx_byte_count != 8'hFF) rx_byte_count <= rx_byte_count + 8'd1;
`endif
          end
        end
        default: begin
          state  <= SEARCH;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_paral_rx_cond.md
SERIAL_PARAL_RX_COND -- requirements
Module: serial_paral_rx_cond

Interface
REQ-001 The block SHALL have parameter COMMA, default 8'hBC: the idle/alignment symbol.
REQ-002 The block SHALL have parameter BC_THRESHOLD, default 4: the number of consecutive aligned COMMA bytes required for lock.
REQ-003 The block SHALL have one clock and a synchronous active-high reset, listed first as ports clk_8f and reset.
REQ-004 Port clk_8f  input  1: bit clock, one serial bit per rising edge.
REQ-005 Port reset  input  1: synchronous, active-high; sampled on the rising edge of clk_8f.
REQ-006 Port serial_in  input  1: serial line driven by the phy_tx stage, MSB first.
REQ-007 Port data_out  output  8: last received data byte.
REQ-008 Port valid_out  output  1: one-cycle strobe; data_out holds a new data byte.
REQ-009 Port active  output  1: high while the block is locked (ACTIVE state).

Function
REQ-010 The block SHALL shift serial_in into an 8-bit register every clk_8f edge, MSB first: sr <= {sr[6:0], serial_in}.
REQ-011 The candidate byte in each cycle SHALL be {sr[6:0], serial_in}.
REQ-012 The FSM SHALL have exactly the states SEARCH, LOCKING and ACTIVE.
REQ-013 SEARCH SHALL compare the candidate byte against COMMA every cycle; on a match it SHALL go to LOCKING with bc_count=1 and bit counter cnt=0.
REQ-014 In LOCKING and ACTIVE, cnt SHALL increment every cycle; a byte boundary occurs when cnt==7, after which cnt wraps to 0, giving an 8-cycle period.
REQ-015 In LOCKING at a boundary, a candidate equal to COMMA SHALL increment bc_count; when bc_count reaches BC_THRESHOLD the FSM SHALL go to ACTIVE.
REQ-016 With the default threshold, the 4th consecutive COMMA (3 after the first match) SHALL enter ACTIVE.
REQ-017 In LOCKING at a boundary, a candidate not equal to COMMA SHALL return the FSM to SEARCH with bc_count=0.
REQ-018 That non-COMMA byte SHALL NOT be re-checked for a COMMA match in the same cycle.
REQ-019 In ACTIVE at a boundary, a non-COMMA candidate SHALL set data_out to the candidate byte and pulse valid_out for exactly one cycle.
REQ-020 In ACTIVE at a boundary, a COMMA candidate SHALL hold data_out and keep valid_out=0 (idle).
REQ-021 ACTIVE SHALL persist until reset.
REQ-022 Latency: data_out and valid_out SHALL update on the same edge that samples the byte's last bit (LSB), and become visible in the following cycle.
REQ-023 valid_out SHALL be 0 in every non-boundary cycle and in SEARCH and LOCKING.
REQ-024 active SHALL be registered and equal to (state==ACTIVE).
REQ-025 bc_count SHALL saturate at BC_THRESHOLD and never wrap.

Reset
REQ-026 While reset=1 at a clk_8f edge: state=SEARCH, sr=0, cnt=0, bc_count=0.
REQ-027 While reset=1 at a clk_8f edge: data_out=8'h00, valid_out=0, active=0.
REQ-028 Reset asserted in any state, including mid-byte, SHALL take effect at the next edge.
REQ-029 Any partial byte SHALL be discarded on reset.
REQ-030 Alignment SHALL restart from SEARCH on the first edge after reset deasserts.

Configuration
REQ-031 Macro RX_BYTE_COUNT_EN, when defined, SHALL add output port rx_byte_count (8 bits): a saturating count of valid_out strobes since reset.
REQ-032 rx_byte_count SHALL reset to 0 and stick at 8'hFF once reached.
REQ-033 Without RX_BYTE_COUNT_EN the port and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-034 Reset held 3 cycles, then 32 bits of 0xBC -> active rises after the 4th BC; data_out=00; valid_out never pulses.
REQ-035 4x 0xBC, then 0x5A, 0xBC, 0x3C -> exactly two valid_out pulses, 16 cycles apart, with data_out=5A then 3C; 0xBC is skipped.
REQ-036 3 random bits, then 2x 0xBC, then 0x11 -> FSM returns to SEARCH, active=0; a later 4x 0xBC locks, confirming bit-offset alignment.
REQ-037 Locked stream; reset asserted at cnt=3 mid-byte -> next cycle all outputs are 0; the following byte is not reported until 4 new BCs are seen.
REQ-038 RX_BYTE_COUNT_EN defined; lock, then 300 non-COMMA bytes -> rx_byte_count=FF and holds.
REQ-039 RX_BYTE_COUNT_EN undefined -> the block elaborates without the rx_byte_count port.
